// File: rtl/spi_slave_12bit_rx.sv
// SPI slave receiver: 12-bit words, MSb first, SPI mode set by SPI_MODE.
// Define SPI_SLAVE_RX_FIFO_EN to add a 4-entry receive FIFO with a pop strobe.
`timescale 1ns/1ps
module spi_slave_12bit_rx #(
  parameter int SPI_MODE = 0
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_SPI_Clk,
  input  logic        i_SPI_CS_n,
  input  logic        i_SPI_MOSI,
  input  logic        i_RX_Rd,
  output logic [11:0] o_RX_Word,
  output logic        o_RX_DV,
  output logic        o_Frame_Err,
  output logic        o_Overflow
);

  localparam logic CPOL        = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA        = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam logic SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic        r_sclk_d, r_cs_d;
  logic [1:0]  r_flush;
  logic        r_armed;
  logic [3:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [11:0] r_shift;
  logic        w_sclk, w_cs, w_mosi, w_sample, w_cs_fall;
  logic        w_shift_en, w_deliver, w_err;
  logic [11:0] w_word_new;
  logic        r_frame_err;

  assign w_sclk     = r_sclk_sync[1];
  assign w_cs       = r_cs_sync[1];
  assign w_mosi     = r_mosi_sync[1];
  assign w_sample   = SAMPLE_RISE ? (w_sclk & ~r_sclk_d) : (~w_sclk & r_sclk_d);
  assign w_cs_fall  = ~w_cs & r_cs_d & r_armed;
  assign w_word_new = {r_shift[10:0], w_mosi};

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sclk_sync <= {2{CPOL}};
      r_cs_sync   <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sclk_d    <= CPOL;
      r_cs_d      <= 1'b1;
      r_flush     <= 2'd0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], i_SPI_Clk};
      r_cs_sync   <= {r_cs_sync[0], i_SPI_CS_n};
      r_mosi_sync <= {r_mosi_sync[0], i_SPI_MOSI};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
      if (r_flush != 2'd3) r_flush <= r_flush + 2'd1;
      // A frame may only start once CS_n has been seen high after the reset-loaded values flush out
      if (r_flush == 2'd3 && w_cs) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 12'h000;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_frame_err <= w_err;
      if (w_shift_en) r_shift <= w_word_new;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_en    = 1'b0;
    w_deliver     = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt   = SHIFT;
          w_bit_cnt_nxt = 4'd0;
        end
      end
      SHIFT: begin
        // The 12th sample edge wins over a simultaneous CS_n rise
        if (w_sample) begin
          w_shift_en    = 1'b1;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd11) begin
            w_deliver     = 1'b1;
            w_state_nxt   = WAIT_CS;
            w_bit_cnt_nxt = 4'd0;
          end
        end else if (w_cs) begin
          w_err         = (r_bit_cnt != 4'd0);
          w_state_nxt   = IDLE;
          w_bit_cnt_nxt = 4'd0;
        end
      end
      WAIT_CS: begin
        if (w_cs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_Frame_Err = r_frame_err;

`ifdef SPI_SLAVE_RX_FIFO_EN
  logic [11:0] r_fifo [4];
  logic [1:0]  r_wp, r_rp;
  logic [2:0]  r_count;
  logic        r_ovf;
  logic        w_full, w_empty, w_pop, w_push;

  assign w_full  = (r_count == 3'd4);
  assign w_empty = (r_count == 3'd0);
  assign w_pop   = i_RX_Rd & ~w_empty;
  assign w_push  = w_deliver & (~w_full | w_pop);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= 12'h000;
      r_wp    <= 2'd0;
      r_rp    <= 2'd0;
      r_count <= 3'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= w_word_new;
        r_wp         <= r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      r_ovf   <= w_deliver & w_full & ~w_pop;
    end
  end

  assign o_RX_Word  = r_fifo[r_rp];
  assign o_RX_DV    = ~w_empty;
  assign o_Overflow = r_ovf;
`else
  logic [11:0] r_word;
  logic        r_dv;
  logic        w_unused_rd;

  assign w_unused_rd = i_RX_Rd;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_word <= 12'h000;
      r_dv   <= 1'b0;
    end else begin
      r_dv <= w_deliver;
      if (w_deliver) r_word <= w_word_new;
    end
  end

  assign o_RX_Word  = r_word;
  assign o_RX_DV    = r_dv;
  assign o_Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_12bit_rx.sv
// Scoreboard bench for spi_slave_12bit_rx: one instance per SPI mode, randomized frames
// checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_slave_12bit_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic        sclk [4];
  logic        cs_n [4];
  logic        mosi [4];
  logic        rd   [4] = '{default: 1'b0};
  logic        dv   [4];
  logic        ferr [4];
  logic        ovf  [4];
  logic [11:0] word [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_12bit_rx #(.SPI_MODE(g)) u_dut (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_SPI_Clk  (sclk[g]),
      .i_SPI_CS_n (cs_n[g]),
      .i_SPI_MOSI (mosi[g]),
      .i_RX_Rd    (rd[g]),
      .o_RX_Word  (word[g]),
      .o_RX_DV    (dv[g]),
      .o_Frame_Err(ferr[g]),
      .o_Overflow (ovf[g])
    );
  end

  logic [11:0] exp_q [4][$];
  logic [11:0] last_exp [4] = '{default: 12'h000};
  int          exp_err [4] = '{default: 0};
  int          act_err [4] = '{default: 0};
  int          exp_ovf [4] = '{default: 0};
  int          act_ovf [4] = '{default: 0};
  int          n_pass = 0;
  int          n_total = 0;
  bit          drain_en = 1'b1;
  bit          rst_chk = 1'b0, rst_done = 1'b0;
  bit          end_chk = 1'b0, end_done = 1'b0;

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s mode%0d: got %0h expected %0h", nm, m, act, exp);
  endtask

  task automatic pop_cmp(input int m);
    logic [11:0] e;
    if (exp_q[m].size() == 0) begin
      n_total++;
      $display("FAIL unexpected_word mode%0d: got %03h with no word expected", m, word[m]);
    end else begin
      e = exp_q[m].pop_front();
      chk("rx_word", m, {20'd0, word[m]}, {20'd0, e});
    end
  endtask

  // Monitor: consumes delivered words and counts error/overflow pulses
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (ferr[m] === 1'b1) act_err[m]++;
      if (ovf[m] === 1'b1) act_ovf[m]++;
`ifdef SPI_SLAVE_RX_FIFO_EN
      rd[m] = 1'b0;
      if (dv[m] === 1'b1 && drain_en) begin
        pop_cmp(m);
        rd[m] = 1'b1;
      end
`else
      if (dv[m] === 1'b1) pop_cmp(m);
`endif
    end
    if (rst_chk && !rst_done) begin
      for (int m = 0; m < 4; m++) begin
        chk("reset_word", m, {20'd0, word[m]}, 32'd0);
        chk("reset_dv", m, {31'd0, dv[m]}, 32'd0);
        chk("reset_frame_err", m, {31'd0, ferr[m]}, 32'd0);
        chk("reset_overflow", m, {31'd0, ovf[m]}, 32'd0);
      end
      rst_done = 1'b1;
    end
    if (end_chk && !end_done) begin
      for (int m = 0; m < 4; m++) begin
        chk("words_outstanding", m, exp_q[m].size(), 32'd0);
        chk("frame_err_count", m, act_err[m], exp_err[m]);
        chk("overflow_count", m, act_ovf[m], exp_ovf[m]);
        chk("dv_idle", m, {31'd0, dv[m]}, 32'd0);
`ifndef SPI_SLAVE_RX_FIFO_EN
        chk("held_word", m, {20'd0, word[m]}, {20'd0, last_exp[m]});
`endif
      end
      end_done = 1'b1;
    end
  end

  // Reference model: a frame of n bits (MSb first) yields its first 12 bits, or an error if 1..11
  task automatic model(input int m, input logic [31:0] data, input int n);
    logic [11:0] w;
    bit drop;
    drop = 1'b0;
    if (n >= 12) begin
      w = 12'(data >> (n - 12));
`ifdef SPI_SLAVE_RX_FIFO_EN
      drop = !drain_en && (exp_q[m].size() >= 4);
`endif
      if (drop) exp_ovf[m]++;
      else begin
        exp_q[m].push_back(w);
        last_exp[m] = w;
      end
    end else if (n > 0) begin
      exp_err[m]++;
    end
  endtask

  task automatic send_bits(input int m, input logic [31:0] data, input int n, input int half);
    logic cpol, cpha, b;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    for (int i = 0; i < n; i++) begin
      b = data[n - 1 - i];
      if (!cpha) begin
        mosi[m] = b;
        #(half);
        sclk[m] = ~cpol;
        #(half);
        sclk[m] = cpol;
      end else begin
        #(half);
        sclk[m] = ~cpol;
        mosi[m] = b;
        #(half);
        sclk[m] = cpol;
      end
    end
  endtask

  task automatic frame(input int m, input logic [31:0] data, input int n, input int half);
    model(m, data, n);
    cs_n[m] = 1'b0;
    send_bits(m, data, n, half);
    #(half);
    cs_n[m] = 1'b1;
    #(4 * half + 40);
  endtask

  task automatic wait_drain(input int limit);
    for (int c = 0; c < limit; c++) begin
      @(posedge clk);
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          exp_q[2].size() == 0 && exp_q[3].size() == 0) break;
    end
  endtask

  initial begin
    int m, sel, n, half;
    logic [31:0] data;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sclk[i] = (i >= 2);
      cs_n[i] = 1'b1;
      mosi[i] = 1'b0;
    end
    #3;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    rst_chk = 1'b1;
    @(negedge clk);
    #1;

    frame(0, 32'hA55, 12, 40);
    frame(3, 32'h7FF, 12, 40);
    frame(3, 32'h001, 12, 40);
    frame(0, 32'h15, 5, 30);
    frame(0, 32'h3C3, 12, 30);
    frame(1, {18'd0, 12'h5A6, 2'b11}, 14, 25);
    frame(2, 32'hE07, 12, 20);

    for (int r = 0; r < 40; r++) begin
      m    = $urandom_range(0, 3);
      sel  = $urandom_range(0, 9);
      n    = (sel < 6) ? 12 : (sel < 8) ? $urandom_range(1, 11) : (sel == 8) ? $urandom_range(13, 16) : 0;
      data = $urandom;
      half = $urandom_range(20, 60);
      frame(m, data, n, half);
    end

    // Reset in mid-frame with CS_n held low: nothing may be received until CS_n cycles high
    wait_drain(400);
    cs_n[0] = 1'b0;
    send_bits(0, 32'h2A, 6, 40);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) last_exp[i] = 12'h000;
    repeat (6) @(posedge clk);
    send_bits(0, 32'hFFF, 12, 40);
    #40 cs_n[0] = 1'b1;
    #200;
    frame(0, 32'h123, 12, 40);

    wait_drain(400);
`ifdef SPI_SLAVE_RX_FIFO_EN
    drain_en = 1'b0;
`endif
    for (int k = 1; k <= 5; k++) frame(0, k, 12, 40);
`ifdef SPI_SLAVE_RX_FIFO_EN
    repeat (20) @(posedge clk);
    drain_en = 1'b1;
`endif
    wait_drain(500);
    repeat (5) @(posedge clk);
    end_chk = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
